button_events: RTL and testbench
================================

BUTTON_EVENTS -- requirements
Module: button_events

Interface
REQ-001 Parameter TICK_DIV, default 50000: clk cycles per repeat-timebase tick, 2..65535.
REQ-002 Parameter DELAY_TICKS, default 24: ticks a lone held button waits before its first repeat, 1..255.
REQ-003 Parameter RATE_TICKS, default 6: ticks between later repeats, 1..255.
REQ-004 Port list: clk in 1, rising-edge clock; rst_n in 1, asynchronous active-low reset; debounced in 6, stable button levels; pos_edge in 6, one-cycle press pulses; evt_ready in 1, consumer accepts event; evt_valid out 1, event available; evt_code out 3, button index 0..5; evt_repeat out 1, event is auto-repeat; level out 3, FIFO occupancy 0..4; overflow out 1, sticky drop flag; ovf_clr in 1, clears overflow.

Function
REQ-005 Pending register pend[5:0] each cycle SHALL become (pend & ~grant) | pos_edge | rep_pulse.
REQ-006 Grant SHALL select the lowest-index set pend bit, only when the FIFO is not full or is popped that cycle; at most one grant per cycle.
REQ-007 Granted bit SHALL be written to the FIFO one cycle after its pend bit is set, with evt_repeat = 1 iff the latest set of that bit came from rep_pulse.
REQ-008 Setting an already-set pend bit (not granted that cycle) SHALL set overflow; the event merges, no second entry.
REQ-009 FIFO: 4 entries of {repeat, code[2:0]}, first-word fall-through; evt_valid = level != 0; evt_code/evt_repeat show the head entry.
REQ-010 Pop on evt_valid & evt_ready; push and pop in the same cycle SHALL leave level unchanged; evt_ready while empty SHALL be ignored.
REQ-011 Full FIFO: no grant; pend bits wait unchanged, no loss beyond REQ-008 merges.
REQ-012 Prescaler 16-bit SHALL count 0..TICK_DIV-1 and emit a one-cycle tick on wrap.
REQ-013 Repeat FSM states IDLE, DELAY, REPEAT; held = debounced is one-hot; idx = its index.
REQ-014 IDLE->DELAY when held; the tick counter loads DELAY_TICKS and latches idx.
REQ-015 DELAY: decrement on tick; reaching 0 SHALL pulse rep_pulse[idx] and go to REPEAT with the counter loaded to RATE_TICKS.
REQ-016 REPEAT: decrement on tick; reaching 0 SHALL pulse rep_pulse[idx] and reload RATE_TICKS.
REQ-017 In DELAY or REPEAT, if held drops or idx changes, go to IDLE with no pulse that cycle; a different lone button restarts DELAY on the next cycle.
REQ-018 Two or more buttons held SHALL keep the FSM in IDLE; presses still enqueue via pos_edge.
REQ-019 Overflow SHALL set per REQ-008 and clear only on ovf_clr; set and clear in the same cycle SHALL leave it set.

Reset
REQ-020 rst_n low SHALL immediately clear pend, FIFO pointers, level, overflow, prescaler, tick counter and latched idx, and put the FSM in IDLE; evt_valid = 0, evt_code = 0, evt_repeat = 0.
REQ-021 Reset assertion mid-event SHALL discard all queued and pending events; deassertion SHALL be synchronised, first grant no earlier than two cycles after release.

Structure
REQ-022 Shared package SHALL hold button index constants (BTN_UP..BTN_BACK = 0..5), BTN_W=6, CODE_W=3, FIFO_DEPTH=4 and the FSM state encoding.
REQ-023 The FIFO SHALL be a separate sub-module evt_fifo (parameterised width and depth, FWFT, level output); arbitration, prescaler and repeat FSM stay in button_events.
REQ-024 Target size 150-300 RTL lines; no multipliers; all counters saturate-free with explicit reloads.

Verification (TICK_DIV=4, DELAY_TICKS=3, RATE_TICKS=2)
REQ-025 pos_edge=6'b100101 in one cycle, evt_ready=1 -> codes 0,2,5 on consecutive cycles, evt_repeat=0, overflow=0.
REQ-026 evt_ready=0, 6 single presses of buttons 0..5 -> level saturates at 4; codes 4,5 stay pending; with evt_ready=1 the output order is 0..5, overflow=0.
REQ-027 Full FIFO, button 4 pending, pos_edge[4] again -> overflow=1; after drain exactly one code-4 event; ovf_clr -> overflow=0.
REQ-028 Hold button 1 alone for 40 cycles, evt_ready=1 -> one press event, first repeat 12 cycles after FSM entry (±prescaler phase), then every 8 cycles, evt_repeat=1.
REQ-029 Hold 1, add 3 while in DELAY -> FSM IDLE, no repeats; release 1 -> DELAY restarts for button 3.
REQ-030 rst_n low with level=3 and pend nonzero -> evt_valid=0 and level=0 at once; after release no stale events appear.

Source files
------------

// File: rtl/button_events_pkg.sv
// Shared constants, FSM encoding and helpers for the button event queue.
// Button indices double as the event codes presented to the consumer.
package button_events_pkg;

  localparam int BTN_W      = 6;
  localparam int CODE_W     = 3;
  localparam int FIFO_DEPTH = 4;

  localparam logic [CODE_W-1:0] BTN_UP    = 3'd0;
  localparam logic [CODE_W-1:0] BTN_DOWN  = 3'd1;
  localparam logic [CODE_W-1:0] BTN_LEFT  = 3'd2;
  localparam logic [CODE_W-1:0] BTN_RIGHT = 3'd3;
  localparam logic [CODE_W-1:0] BTN_OK    = 3'd4;
  localparam logic [CODE_W-1:0] BTN_BACK  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

  typedef struct packed {
    logic              is_rep;
    logic [CODE_W-1:0] code;
  } evt_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [CODE_W-1:0] lowest_idx(input logic [BTN_W-1:0] v);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = BTN_W - 1; i >= 0; i--) begin
      if (v[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [BTN_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/evt_fifo.sv
// First-word fall-through FIFO with occupancy output; head reads as zero when empty.
module evt_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [LVL_W-1:0] o_level,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_empty   = (r_level == '0);
  assign o_full    = (r_level == LVL_W'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // NOTE: storage has no reset; only pointers and level need a defined state,
  // and the empty-gated output keeps unwritten entries from ever being seen.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_level = r_level;

endmodule

// File: rtl/button_events.sv
// Button press/auto-repeat event generator: pending-bit arbiter feeding a small
// FWFT event queue, plus a prescaled repeat FSM for a single held button.
module button_events
  import button_events_pkg::*;
#(
  parameter int TICK_DIV    = 50000,
  parameter int DELAY_TICKS = 24,
  parameter int RATE_TICKS  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BTN_W-1:0]  debounced,
  input  logic [BTN_W-1:0]  pos_edge,
  input  logic              evt_ready,
  output logic              evt_valid,
  output logic [CODE_W-1:0] evt_code,
  output logic              evt_repeat,
  output logic [2:0]        level,
  output logic              overflow,
  input  logic              ovf_clr
);

  logic [1:0]        r_rst_sync;
  logic              w_run;
  logic [15:0]       r_presc;
  logic              w_tick;
  rep_state_e        r_state, w_state_nxt;
  logic [7:0]        r_tick_cnt, w_tick_cnt_nxt;
  logic [CODE_W-1:0] r_idx, w_idx_nxt;
  logic              w_held;
  logic [CODE_W-1:0] w_held_idx;
  logic [BTN_W-1:0]  w_rep_pulse;
  logic [BTN_W-1:0]  r_pend;
  logic [BTN_W-1:0]  r_rep_flag;
  logic [BTN_W-1:0]  w_set;
  logic [BTN_W-1:0]  w_grant;
  logic [CODE_W-1:0] w_grant_idx;
  logic              w_can_grant;
  logic              w_ovf_hit;
  logic              r_ovf;
  logic              w_pop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  evt_t              w_push_data;
  evt_t              w_head;

  // Release is synchronised; nothing is captured until two edges after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= '0;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_run = r_rst_sync[1];

  assign w_tick = w_run && (r_presc == 16'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_presc <= '0;
    else if (w_run) r_presc <= w_tick ? '0 : r_presc + 1'b1;
  end

  assign w_held     = is_onehot(debounced);
  assign w_held_idx = lowest_idx(debounced);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_tick_cnt_nxt = r_tick_cnt;
    w_idx_nxt      = r_idx;
    w_rep_pulse    = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_held) begin
          w_state_nxt    = ST_DELAY;
          w_tick_cnt_nxt = 8'(DELAY_TICKS);
          w_idx_nxt      = w_held_idx;
        end
      end
      ST_DELAY, ST_REPEAT: begin
        if (!w_held || (w_held_idx != r_idx)) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tick) begin
          if (r_tick_cnt == 8'd1) begin
            w_rep_pulse    = BTN_W'(1) << r_idx;
            w_state_nxt    = ST_REPEAT;
            w_tick_cnt_nxt = 8'(RATE_TICKS);
          end else begin
            w_tick_cnt_nxt = r_tick_cnt - 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_tick_cnt <= '0;
      r_idx      <= '0;
    end else if (w_run) begin
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_cnt_nxt;
      r_idx      <= w_idx_nxt;
    end
  end

  assign w_pop       = evt_valid & evt_ready;
  assign w_can_grant = w_run & (~w_fifo_full | w_pop);
  assign w_grant_idx = lowest_idx(r_pend);
  assign w_grant     = (w_can_grant && (r_pend != '0)) ? (BTN_W'(1) << w_grant_idx) : '0;
  assign w_set       = (pos_edge | w_rep_pulse) & {BTN_W{w_run}};
  assign w_ovf_hit   = |(w_set & r_pend & ~w_grant);

  // A set bit not coming from pos_edge came from the repeat FSM; a press wins a tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend     <= '0;
      r_rep_flag <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_pend     <= (r_pend & ~w_grant) | w_set;
      r_rep_flag <= (r_rep_flag & ~w_set) | (w_set & ~pos_edge);
      if (w_ovf_hit)    r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign w_push_data.is_rep = r_rep_flag[w_grant_idx];
  assign w_push_data.code   = w_grant_idx;

  evt_fifo #(
    .WIDTH ($bits(evt_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (|w_grant),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_level (level),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign evt_valid  = ~w_fifo_empty;
  assign evt_code   = w_head.code;
  assign evt_repeat = w_head.is_rep;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events: stimulus pushes expected events into a
// scoreboard queue, an independent monitor pops and compares on every handshake.
module tb_button_events;
  import button_events_pkg::*;

  localparam int TICK_DIV    = 4;
  localparam int DELAY_TICKS = 3;
  localparam int RATE_TICKS  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [BTN_W-1:0]  debounced = '0;
  logic [BTN_W-1:0]  pos_edge = '0;
  logic              evt_ready = 1'b0;
  logic              ovf_clr = 1'b0;
  logic              evt_valid;
  logic [CODE_W-1:0] evt_code;
  logic              evt_repeat;
  logic [2:0]        level;
  logic              overflow;

  typedef struct {
    logic [CODE_W-1:0] code;
    logic              rep;
  } exp_t;

  exp_t exp_q[$];
  int   pop_cyc[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  button_events #(
    .TICK_DIV    (TICK_DIV),
    .DELAY_TICKS (DELAY_TICKS),
    .RATE_TICKS  (RATE_TICKS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .debounced  (debounced),
    .pos_edge   (pos_edge),
    .evt_ready  (evt_ready),
    .evt_valid  (evt_valid),
    .evt_code   (evt_code),
    .evt_repeat (evt_repeat),
    .level      (level),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic expect_evt(input logic [CODE_W-1:0] code, input logic rep);
    exp_t e;
    e.code = code;
    e.rep  = rep;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted event must match the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && evt_valid === 1'b1 && evt_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_evt: got code %0d repeat %0d, required no event", evt_code, evt_repeat);
      end else begin
        e = exp_q.pop_front();
        check("evt_code", 32'(evt_code), 32'(e.code));
        check("evt_repeat", 32'(evt_repeat), 32'(e.rep));
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 32'(evt_valid), 32'd0);
    check({tag, "_code"}, 32'(evt_code), 32'd0);
    check({tag, "_repeat"}, 32'(evt_repeat), 32'd0);
    check({tag, "_level"}, 32'(level), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  task automatic finish_reset();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (4) step();
  endtask

  initial begin : watchdog
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int d;

    // Reset state
    #2;
    check_idle_outputs("reset");
    finish_reset();

    // Three simultaneous presses drain on consecutive cycles, lowest index first
    evt_ready = 1'b1;
    pop_cyc.delete();
    expect_evt(3'd0, 1'b0);
    expect_evt(3'd2, 1'b0);
    expect_evt(3'd5, 1'b0);
    pos_edge = 6'b100101;
    step();
    pos_edge = '0;
    wait_drain("multi_press_drain", 20);
    check("multi_press_count", 32'(pop_cyc.size()), 32'd3);
    if (pop_cyc.size() == 3) begin
      check("multi_press_gap0", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
      check("multi_press_gap1", 32'(pop_cyc[2] - pop_cyc[1]), 32'd1);
    end
    check("multi_press_ovf", 32'(overflow), 32'd0);

    // Six single presses with consumer stalled: queue fills, 4 and 5 wait
    evt_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pos_edge = BTN_W'(1) << i;
      expect_evt(CODE_W'(i), 1'b0);
      step();
    end
    pos_edge = '0;
    repeat (6) step();
    check("stall_level_full", 32'(level), 32'd4);
    check("stall_valid", 32'(evt_valid), 32'd1);
    check("stall_head_code", 32'(evt_code), 32'd0);
    evt_ready = 1'b1;
    wait_drain("stall_drain", 30);
    check("stall_ovf", 32'(overflow), 32'd0);
    check("stall_level_empty", 32'(level), 32'd0);

    // Full queue, button 4 pending, pressed again with ovf_clr in the same cycle
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) expect_evt(CODE_W'(i), 1'b0);
    pos_edge = 6'b011111;
    step();
    pos_edge = '0;
    repeat (6) step();
    check("ovf_pre_level", 32'(level), 32'd4);
    check("ovf_pre_flag", 32'(overflow), 32'd0);
    pos_edge = 6'b010000;
    ovf_clr  = 1'b1;
    step();
    pos_edge = '0;
    ovf_clr  = 1'b0;
    step();
    check("ovf_set_beats_clr", 32'(overflow), 32'd1);
    repeat (3) step();
    check("ovf_sticky", 32'(overflow), 32'd1);
    evt_ready = 1'b1;
    wait_drain("ovf_drain", 30);
    repeat (10) step();
    check("ovf_after_drain", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    step();
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Hold button 1 alone for 40 cycles: one press then exactly four repeats
    pop_cyc.delete();
    expect_evt(3'd1, 1'b0);
    for (int i = 0; i < 4; i++) expect_evt(3'd1, 1'b1);
    debounced = 6'b000010;
    pos_edge  = 6'b000010;
    step();
    pos_edge = '0;
    repeat (39) step();
    debounced = '0;
    wait_drain("hold_drain", 30);
    repeat (20) step();
    check("hold_event_count", 32'(pop_cyc.size()), 32'd5);
    if (pop_cyc.size() == 5) begin
      d = pop_cyc[1] - pop_cyc[0];
      check("hold_first_gap_9_to_12", 32'((d >= 9) && (d <= 12)), 32'd1);
      check("hold_rate_gap0", 32'(pop_cyc[2] - pop_cyc[1]), 32'd8);
      check("hold_rate_gap1", 32'(pop_cyc[3] - pop_cyc[2]), 32'd8);
      check("hold_rate_gap2", 32'(pop_cyc[4] - pop_cyc[3]), 32'd8);
    end

    // Second button joins during DELAY: no repeats; releasing 1 restarts for 3
    pop_cyc.delete();
    expect_evt(3'd1, 1'b0);
    debounced = 6'b000010;
    pos_edge  = 6'b000010;
    step();
    pos_edge = '0;
    repeat (4) step();
    expect_evt(3'd3, 1'b0);
    debounced = 6'b001010;
    pos_edge  = 6'b001000;
    step();
    pos_edge = '0;
    repeat (30) step();
    check("two_held_events", 32'(pop_cyc.size()), 32'd2);
    expect_evt(3'd3, 1'b1);
    debounced = 6'b001000;
    repeat (15) step();
    debounced = '0;
    wait_drain("restart_drain", 30);
    repeat (20) step();
    check("restart_event_count", 32'(pop_cyc.size()), 32'd3);

    // Reset mid-event with three queued and two pending
    evt_ready = 1'b0;
    pos_edge  = 6'b011111;
    step();
    pos_edge = '0;
    repeat (3) step();
    check("midreset_pre_level", 32'(level), 32'd3);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midreset_valid", 32'(evt_valid), 32'd0);
    check("midreset_level", 32'(level), 32'd0);
    check("midreset_code", 32'(evt_code), 32'd0);
    finish_reset();
    evt_ready = 1'b1;
    repeat (20) step();
    check("post_reset_level", 32'(level), 32'd0);
    check("post_reset_valid", 32'(evt_valid), 32'd0);
    check("post_reset_scoreboard", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
